// File: rtl/freelist.sv
// Circular free list of physical registers feeding dual-slot rename.
// Commit-tracked head lets a flush rewind all speculative allocations.
module freelist #(
  parameter  int PREG_NUM = 64,
  parameter  int ARCH_NUM = 32,
  parameter  int DEPTH    = PREG_NUM - ARCH_NUM,
  localparam int PW       = $clog2(PREG_NUM),
  localparam int IW       = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          instr0_freelist_req,
  output logic [PW-1:0] instr0_freelist_resp,
  input  logic          instr1_freelist_req,
  output logic [PW-1:0] instr1_freelist_resp,
  output logic          freelist_can_alloc,
  input  logic          free0_valid,
  input  logic [PW-1:0] free0_preg,
  input  logic          free1_valid,
  input  logic [PW-1:0] free1_preg,
  input  logic          commit0_alloc,
  input  logic          commit1_alloc,
  input  logic          flush,
  output logic [PW:0]   free_count
);

  typedef logic [IW:0] ptr_t;

  logic [PW-1:0] queue_q [DEPTH];
  ptr_t          head_q, head_d;
  ptr_t          tail_q, tail_d;
  ptr_t          chead_q, chead_d;
  ptr_t          count;
  logic [IW-1:0] hidx, hidx1;
  logic [IW-1:0] tidx0, tidx1;
  logic [1:0]    pop, push, cinc;

  // wrap bit makes tail - head distinguish full from empty
  assign count = tail_q - head_q;
  assign free_count = (PW+1)'(count);
  assign freelist_can_alloc = (count >= ptr_t'(2)) && !flush;

  assign hidx  = head_q[IW-1:0];
  assign hidx1 = hidx + IW'(1);
  assign tidx0 = tail_q[IW-1:0];
  assign tidx1 = tidx0 + IW'(free0_valid);

  assign instr0_freelist_resp = queue_q[hidx];
  assign instr1_freelist_resp = instr0_freelist_req ? queue_q[hidx1]
                                                    : queue_q[hidx];

  assign pop  = freelist_can_alloc
              ? {1'b0, instr0_freelist_req} + {1'b0, instr1_freelist_req}
              : 2'd0;
  assign push = {1'b0, free0_valid} + {1'b0, free1_valid};
  assign cinc = {1'b0, commit0_alloc} + {1'b0, commit1_alloc};

  assign chead_d = chead_q + ptr_t'(cinc);
  assign tail_d  = tail_q + ptr_t'(push);
  // flush drops same-cycle pops and rewinds to the committed point
  assign head_d  = flush ? chead_d : head_q + ptr_t'(pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        queue_q[i] <= PW'(ARCH_NUM + i);
      end
      head_q  <= '0;
      chead_q <= '0;
      tail_q  <= ptr_t'(DEPTH);
    end else begin
      if (free0_valid) queue_q[tidx0] <= free0_preg;
      if (free1_valid) queue_q[tidx1] <= free1_preg;
      head_q  <= head_d;
      chead_q <= chead_d;
      tail_q  <= tail_d;
    end
  end

endmodule
